// File: rtl/icache_responder.sv
// -----------------------------------------------------------------------------
// icache_responder
//
// Direct-mapped, read-only instruction cache sitting on the fetch interface.
// Hits are answered combinationally in the same cycle. On a miss the fetch
// stage is stalled while a whole line is refilled from memory over a
// valid/ready request followed by an ascending-order beat stream.
//
// Ports:
//   i_clk, i_arst        clock, synchronous active-high reset
//   i_req_valid          fetch presents a lookup this cycle
//   i_req_addr           fetch PC (bits [1:0] ignored)
//   o_instruction        instruction word, meaningful when o_hit=1 (0 otherwise)
//   o_hit                combinational lookup hit (only ever high in IDLE)
//   o_stall              fetch must hold its PC and not capture o_instruction
//   o_mem_req_valid      line refill request
//   o_mem_req_addr       line-aligned refill address
//   i_mem_req_ready      memory accepts the refill request
//   i_mem_data_valid     one refill beat present
//   i_mem_data           refill beat data, word 0 first
//
// Optional feature, macro ICACHE_STATS_EN:
//   o_hit_count, o_miss_count  32-bit saturating hit/miss counters.
// -----------------------------------------------------------------------------
module icache_responder #(
    parameter int ADDR_WIDTH     = 64,
    parameter int INSTR_WIDTH    = 32,
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_req_valid,
    input  logic [ADDR_WIDTH-1:0]  i_req_addr,
    output logic [INSTR_WIDTH-1:0] o_instruction,
    output logic                   o_hit,
    output logic                   o_stall,
    output logic                   o_mem_req_valid,
    output logic [ADDR_WIDTH-1:0]  o_mem_req_addr,
    input  logic                   i_mem_req_ready,
    input  logic                   i_mem_data_valid,
    input  logic [INSTR_WIDTH-1:0] i_mem_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]            o_hit_count,
    output logic [31:0]            o_miss_count
`endif
);

    localparam int OFFSET_W = $clog2(WORDS_PER_LINE * 4);
    localparam int INDEX_W  = $clog2(SETS);
    localparam int TAG_W    = ADDR_WIDTH - OFFSET_W - INDEX_W;
    localparam int WORD_W   = $clog2(WORDS_PER_LINE);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REFILL,
        UPDATE
    } state_t;

    state_t state_q, state_d;

    logic [SETS-1:0]        valid_q;
    logic [TAG_W-1:0]       tag_mem  [SETS];
    logic [INSTR_WIDTH-1:0] data_mem [SETS][WORDS_PER_LINE];

    logic [ADDR_WIDTH-1:0]  miss_addr_q;
    logic [WORD_W-1:0]      cnt_q;

    // Lookup fields of the incoming PC
    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [WORD_W-1:0]  req_word;
    logic               lookup_hit;

    // Line being refilled
    logic [INDEX_W-1:0] miss_idx;
    logic [TAG_W-1:0]   miss_tag;

    // Byte-offset bits within a word never select anything
    logic unused_addr_bits;

    assign req_idx          = i_req_addr[OFFSET_W +: INDEX_W];
    assign req_tag          = i_req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign req_word         = i_req_addr[2 +: WORD_W];
    assign miss_idx         = miss_addr_q[OFFSET_W +: INDEX_W];
    assign miss_tag         = miss_addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign unused_addr_bits = ^i_req_addr[1:0];

    assign lookup_hit = i_req_valid && valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    // The address register is held (not cleared) outside REQ so the request
    // address stays stable for the whole handshake.
    assign o_mem_req_addr = miss_addr_q;

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        o_hit           = 1'b0;
        o_stall         = 1'b1;
        o_mem_req_valid = 1'b0;
        o_instruction   = '0;

        case (state_q)
            IDLE: begin
                o_stall = 1'b0;
                if (lookup_hit) begin
                    o_hit         = 1'b1;
                    o_instruction = data_mem[req_idx][req_word];
                end else if (i_req_valid) begin
                    o_stall = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                o_mem_req_valid = 1'b1;
                if (i_mem_req_ready) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (i_mem_data_valid && (cnt_q == WORD_W'(WORDS_PER_LINE - 1))) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control state: FSM, valid bits, miss address, beat counter
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            miss_addr_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q <= state_d;

            if ((state_q == IDLE) && (state_d == REQ)) begin
                miss_addr_q <= {i_req_addr[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
            end

            if ((state_q == REQ) && i_mem_req_ready) begin
                cnt_q <= '0;
            end else if ((state_q == REFILL) && i_mem_data_valid) begin
                cnt_q <= cnt_q + 1'b1;
            end

            // Valid is only raised once every word of the line has landed
            if (state_q == UPDATE) begin
                valid_q[miss_idx] <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Tag and data arrays (no reset; guarded by valid_q)
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if ((state_q == REFILL) && i_mem_data_valid) begin
            data_mem[miss_idx][cnt_q] <= i_mem_data;
        end
        if (state_q == UPDATE) begin
            tag_mem[miss_idx] <= miss_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    // -------------------------------------------------------------------------
    // Saturating hit / miss counters
    // -------------------------------------------------------------------------
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (o_hit && (hit_count_q != 32'hFFFF_FFFF)) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if ((state_q == IDLE) && (state_d == REQ) && (miss_count_q != 32'hFFFF_FFFF)) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign o_hit_count  = hit_count_q;
    assign o_miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// -----------------------------------------------------------------------------
// tb_icache_responder
//
// Scoreboard bench for icache_responder. Every lookup pushes the instruction
// the bench's memory model holds for that PC; the entry is popped and compared
// when the DUT raises o_hit. A behavioural memory responder inside the lookup
// task serves refills with configurable request-ready delay and beat gaps.
// Build with +define+ICACHE_STATS_EN to also cover the statistics counters.
// -----------------------------------------------------------------------------
module tb_icache_responder;

    logic        i_clk;
    logic        i_arst;
    logic        i_req_valid;
    logic [63:0] i_req_addr;
    logic [31:0] o_instruction;
    logic        o_hit;
    logic        o_stall;
    logic        o_mem_req_valid;
    logic [63:0] o_mem_req_addr;
    logic        i_mem_req_ready;
    logic        i_mem_data_valid;
    logic [31:0] i_mem_data;
`ifdef ICACHE_STATS_EN
    logic [31:0] o_hit_count;
    logic [31:0] o_miss_count;
`endif

    icache_responder #(
        .ADDR_WIDTH     (64),
        .INSTR_WIDTH    (32),
        .SETS           (16),
        .WORDS_PER_LINE (4)
    ) dut (
        .i_clk            (i_clk),
        .i_arst           (i_arst),
        .i_req_valid      (i_req_valid),
        .i_req_addr       (i_req_addr),
        .o_instruction    (o_instruction),
        .o_hit            (o_hit),
        .o_stall          (o_stall),
        .o_mem_req_valid  (o_mem_req_valid),
        .o_mem_req_addr   (o_mem_req_addr),
        .i_mem_req_ready  (i_mem_req_ready),
        .i_mem_data_valid (i_mem_data_valid),
        .i_mem_data       (i_mem_data)
`ifdef ICACHE_STATS_EN
        ,
        .o_hit_count      (o_hit_count),
        .o_miss_count     (o_miss_count)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    int exp_hits   = 0;
    int exp_misses = 0;

    logic [31:0] sb[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Backing memory contents: line 0x40 holds 0x11,0x22,0x33,0x44
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [63:0] line;
        logic [1:0]  w;
        line = a & ~64'hF;
        w    = a[3:2];
        if (line == 64'h40) begin
            return 32'h11 * (32'(w) + 32'd1);
        end
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hit"},       64'(o_hit),           64'd0);
        check({tag, "_stall"},     64'(o_stall),         64'd0);
        check({tag, "_mreq_vld"},  64'(o_mem_req_valid), 64'd0);
        check({tag, "_mreq_addr"}, o_mem_req_addr,       64'd0);
        check({tag, "_instr"},     64'(o_instruction),   64'd0);
`ifdef ICACHE_STATS_EN
        check({tag, "_hit_cnt"},   64'(o_hit_count),     64'd0);
        check({tag, "_miss_cnt"},  64'(o_miss_count),    64'd0);
`endif
    endtask

    // Called at posedge+1. Presents one lookup, serves any refill, and returns
    // at posedge+1 of the cycle after the hit.
    task automatic fetch(input logic [63:0] addr, input int rdy_dly, input int gap,
                         input int exp_stall);
        int          stall_n = 0;
        int          rdy_n   = 0;
        int          beat    = 0;
        int          gap_n   = 0;
        int          phase   = 0;
        bit          served  = 0;
        logic [63:0] line;
        logic [31:0] exp_i;
        line = addr & ~64'hF;
        sb.push_back(mem_word(addr));
        i_req_valid = 1'b1;
        i_req_addr  = addr;
        for (int cyc = 0; cyc < 200 && !served; cyc++) begin
            i_mem_req_ready  = 1'b0;
            i_mem_data_valid = 1'b0;
            if (phase == 0 && o_mem_req_valid) begin
                check("req_addr", o_mem_req_addr, line);
                if (rdy_n < rdy_dly) begin
                    rdy_n++;
                end else begin
                    i_mem_req_ready = 1'b1;
                    phase = 1;
                end
            end else if (phase == 1) begin
                if (gap_n < gap) begin
                    gap_n++;
                end else begin
                    i_mem_data_valid = 1'b1;
                    i_mem_data       = mem_word(line + 64'(4 * beat));
                    beat++;
                    gap_n = 0;
                    if (beat == 4) phase = 2;
                end
            end
            @(negedge i_clk);
            if (o_stall) stall_n++;
            check("hit_and_stall", 64'(o_hit & o_stall), 64'd0);
            if (o_hit) begin
                exp_i = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
                check("instr", 64'(o_instruction), 64'(exp_i));
                served = 1;
            end
            @(posedge i_clk);
            #1;
        end
        i_mem_req_ready  = 1'b0;
        i_mem_data_valid = 1'b0;
        check("served", 64'(served), 64'd1);
        if (!served && sb.size() > 0) void'(sb.pop_front());
        check("stall_cycles", 64'(stall_n), 64'(exp_stall));
        if (exp_stall > 0) exp_misses++;
        if (served) exp_hits++;
    endtask

    initial begin
        i_arst           = 1'b1;
        i_req_valid      = 1'b0;
        i_req_addr       = '0;
        i_mem_req_ready  = 1'b0;
        i_mem_data_valid = 1'b0;
        i_mem_data       = '0;
        repeat (3) @(posedge i_clk);
        #1;
        i_arst = 1'b0;
        @(negedge i_clk);
        check_reset_outputs("rst");
        @(posedge i_clk);
        #1;

        // Cold miss, then same-line hits, back to back
        fetch(64'h40,  0, 0, 7);
        fetch(64'h44,  0, 0, 0);
        fetch(64'h4C,  0, 0, 0);

        // Conflict on index 4 evicts line 0x40
        fetch(64'h140, 0, 0, 7);
        fetch(64'h40,  0, 0, 7);
        fetch(64'h148, 0, 0, 7);
        fetch(64'h40,  0, 0, 7);

        // Back-pressure: 3 cycles of ready low, 2 idle cycles before each beat
        fetch(64'h208, 3, 2, 3 + 4 + 3 + 4 * 2);
        fetch(64'h204, 0, 0, 0);
        fetch(64'h48,  0, 0, 0);

        // Reset in the middle of a refill of line 0x80
        i_req_valid = 1'b1;
        i_req_addr  = 64'h80;
        @(posedge i_clk); #1;
        i_mem_req_ready = 1'b1;
        @(posedge i_clk); #1;
        i_mem_req_ready  = 1'b0;
        i_mem_data_valid = 1'b1;
        i_mem_data       = mem_word(64'h80);
        @(posedge i_clk); #1;
        i_mem_data = mem_word(64'h84);
        @(posedge i_clk); #1;
        i_mem_data_valid = 1'b0;
        i_req_valid      = 1'b0;
        i_arst           = 1'b1;
        @(posedge i_clk); #1;
        i_arst = 1'b0;
        @(negedge i_clk);
        check_reset_outputs("midrst");
        @(posedge i_clk); #1;
        exp_hits   = 0;
        exp_misses = 0;

        // Cache was invalidated: 0x40 misses again
        fetch(64'h40, 0, 0, 7);
        fetch(64'h44, 0, 0, 0);
        fetch(64'h84, 0, 0, 7);

`ifdef ICACHE_STATS_EN
        check("hit_count",  64'(o_hit_count),  64'(exp_hits));
        check("miss_count", 64'(o_miss_count), 64'(exp_misses));
        force dut.hit_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.hit_count_q;
        fetch(64'h48, 0, 0, 0);
        check("hit_count_sat",  64'(o_hit_count),  64'hFFFF_FFFF);
        check("miss_count_end", 64'(o_miss_count), 64'(exp_misses));
`endif

        i_req_valid = 1'b0;
        @(negedge i_clk);
        check("idle_stall", 64'(o_stall), 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
